nexys_starship_shooter: RTL and testbench
=========================================

// Module: nexys_starship_shooter
// PURPOSE
//  Player-side controller for the four monster lanes (top/right/bottom/left).
//  Drives each lane SM's monster_ctrl and gameover_ctrl, and reads back monster_sm / per-lane gameover.
//  Turns debounced fire pulses plus the aim direction into kills, score, cooldown and game-over aggregation.
//  Sits between the button/debounce logic and the four lane SMs; score feeds the SSD/VGA display.
// PARAMETERS
//  COOLDOWN_CYCLES  8'd50  Clk cycles after any shot before the next fire is accepted (>=1).
//  KILL_HOLD        4'd8   max cycles monster_ctrl[lane] is held low waiting for monster_sm[lane] to drop.
// PORTS
//  Clk              in   1  system clock, all state on posedge
//  Reset            in   1  asynchronous, active-low (0 = reset)
//  play_flag        in   1  level; 1 = play requested
//  fire             in   1  single-cycle debounced fire pulse
//  aim              in   2  0=top 1=right 2=bottom 3=left
//  monster_sm       in   4  per-lane monster-present, bit index = aim code
//  monster_gameover in   4  per-lane gameover flags from the lane SMs
//  monster_ctrl     out  4  per-lane ctrl; lane SM copies it into monster_sm every Clk
//  gameover_ctrl    out  1  global game-over to all lanes
//  score            out  8  kill count, saturates at 255
//  hit_pulse        out  1  1-cycle pulse on a kill
//  miss_pulse       out  1  1-cycle pulse on a shot at an empty lane
//  q_Idle, q_Ready, q_Cool, q_Over  out  1 each  one-hot state
// BEHAVIOUR
//  Reset (Reset==0): state IDLE, monster_ctrl=0, gameover_ctrl=0, score=0, pulses=0, counters=0, kill_pending=0.
//  All outputs are registered; 1-cycle latency from the sampled inputs.
//  IDLE: monster_ctrl=0, score cleared; play_flag==1 -> READY.
//  READY: fire==1 samples aim and monster_sm in the same cycle.
//    Hit (monster_sm[aim]==1 and kill_pending[aim]==0): kill_pending[aim]<=1, score+1 (sat), hit_pulse, -> COOL.
//    Miss: miss_pulse, -> COOL.
//  COOL: counter runs 0..COOLDOWN_CYCLES-1, then -> READY. fire ignored; no pulses.
//  Any state except IDLE: |monster_gameover==1 -> OVER. This takes priority over a same-cycle fire; no score change.
//  OVER: gameover_ctrl=1, monster_ctrl=0, score held. play_flag==0 -> IDLE; gameover_ctrl drops in that cycle.
//  Lane ctrl, per lane, in READY/COOL:
//    kill_pending==0: monster_ctrl[l] <= monster_sm[l] (keeps a lane SM's self-set monster alive).
//    kill_pending==1: monster_ctrl[l] <= 0.
//    kill_pending clears when monster_sm[l]==0 is sampled, or after KILL_HOLD cycles (timeout).
//  A second fire at a lane with kill_pending==1 is a miss.
//  A monster spawning (monster_sm rise) in the same cycle as a fire at that lane counts as a hit.
//  Asserting Reset mid-game returns everything to reset values immediately (async).
// CONFIGURATION
//  NEXYS_STARSHIP_MISS_PENALTY_EN defined: a miss also decrements score by 1, floor 0 (0 stays 0).
//  Not defined: a miss only pulses miss_pulse; score untouched.
// STRUCTURE
//  nexys_starship_pkg: lane index localparams (LANE_TOP..LANE_LEFT), state encodings, score width.
//  Sub-module nexys_starship_lane_ctrl, instantiated 4x: kill_pending flag, KILL_HOLD timer, monster_ctrl bit.
//  Top level: FSM, cooldown counter, score, pulses.
// TESTING
//  Reset=0, then release; play_flag=1 -> q_Ready at cycle 2, all outputs 0.
//  monster_sm=4'b0001 held, aim=0, fire pulse -> hit_pulse, score=1; monster_ctrl[0]=0 until monster_sm[0] drops; q_Cool for 50 cycles.
//  aim=2 with monster_sm[2]=0, fire -> miss_pulse, score unchanged (macro on: score 1->0, 0->0).
//  Fire during COOL -> no pulse, no score change; fire 1 cycle after returning to READY is accepted.
//  monster_gameover[3]=1 in the same cycle as a hitting fire -> OVER, gameover_ctrl=1, score unchanged; play_flag=0 -> IDLE.
//  score forced to 255 by 255 hits, one more hit -> stays 255; lane never drops monster_sm -> ctrl released after 8 cycles.

Source files
------------

// File: rtl/nexys_starship_pkg.sv
// Shared lane indices, state encoding and widths for the starship shooter player controller.
package nexys_starship_pkg;

  localparam logic [1:0] LANE_TOP    = 2'd0;
  localparam logic [1:0] LANE_RIGHT  = 2'd1;
  localparam logic [1:0] LANE_BOTTOM = 2'd2;
  localparam logic [1:0] LANE_LEFT   = 2'd3;

  localparam int NUM_LANES = 4;
  localparam int SCORE_W   = 8;
  localparam int HOLD_W    = 4;
  localparam int COOL_W    = 8;

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  // One-hot encoding so the q_* state outputs are plain register bits.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_READY = 4'b0010,
    ST_COOL  = 4'b0100,
    ST_OVER  = 4'b1000
  } state_t;

endpackage

// File: rtl/nexys_starship_lane_ctrl.sv
// Per-lane kill tracking: holds the lane's monster_ctrl low after a kill until the lane
// SM drops its monster or the KILL_HOLD timeout expires.
module nexys_starship_lane_ctrl
  import nexys_starship_pkg::*;
#(
  parameter logic [HOLD_W-1:0] KILL_HOLD = 4'd8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_active,
  input  logic i_kill,
  input  logic i_monsterSm,
  output logic o_killPending,
  output logic o_monsterCtrl
);

  logic              r_pending;
  logic [HOLD_W-1:0] r_holdCnt;
  logic              r_ctrl;
  logic              w_pendNext;
  logic [HOLD_W-1:0] w_holdNext;

  always_comb begin
    w_pendNext = r_pending;
    w_holdNext = '0;
    if (!i_active) begin
      w_pendNext = 1'b0;
    end else if (i_kill) begin
      w_pendNext = 1'b1;
    end else if (r_pending) begin
      if (!i_monsterSm || (r_holdCnt == KILL_HOLD - HOLD_W'(1))) begin
        w_pendNext = 1'b0;
      end else begin
        w_holdNext = r_holdCnt + HOLD_W'(1);
      end
    end
  end

  // Ctrl uses the next pending value so the kill takes effect on the same edge as the hit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending <= 1'b0;
      r_holdCnt <= '0;
      r_ctrl    <= 1'b0;
    end else begin
      r_pending <= w_pendNext;
      r_holdCnt <= w_holdNext;
      r_ctrl    <= i_active & ~w_pendNext & i_monsterSm;
    end
  end

  assign o_killPending = r_pending;
  assign o_monsterCtrl = r_ctrl;

endmodule

// File: rtl/nexys_starship_shooter.sv
// Player-side shooter controller: FSM, cooldown, score and pulses over four lane controllers.
// Optional: define NEXYS_STARSHIP_MISS_PENALTY_EN to make a miss decrement the score (floor 0).
module nexys_starship_shooter
  import nexys_starship_pkg::*;
#(
  parameter logic [COOL_W-1:0] COOLDOWN_CYCLES = 8'd50,
  parameter logic [HOLD_W-1:0] KILL_HOLD       = 4'd8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_playFlag,
  input  logic                 i_fire,
  input  logic [1:0]           i_aim,
  input  logic [NUM_LANES-1:0] i_monsterSm,
  input  logic [NUM_LANES-1:0] i_monsterGameover,
  output logic [NUM_LANES-1:0] o_monsterCtrl,
  output logic                 o_gameoverCtrl,
  output logic [SCORE_W-1:0]   o_score,
  output logic                 o_hitPulse,
  output logic                 o_missPulse,
  output logic                 o_qIdle,
  output logic                 o_qReady,
  output logic                 o_qCool,
  output logic                 o_qOver
);

  state_t               r_state, w_nextState;
  logic [COOL_W-1:0]    r_coolCnt, w_coolNext;
  logic [SCORE_W-1:0]   r_score, w_scoreNext;
  logic                 r_hitPulse, r_missPulse, r_gameoverCtrl;
  logic                 w_fireHit, w_fireMiss, w_active;
  logic [NUM_LANES-1:0] w_killPending, w_kill;

  // Game-over from any lane outranks a same-cycle fire in READY and COOL.
  always_comb begin
    w_nextState = r_state;
    w_fireHit   = 1'b0;
    w_fireMiss  = 1'b0;
    case (r_state)
      ST_IDLE: if (i_playFlag) w_nextState = ST_READY;
      ST_READY: begin
        if (|i_monsterGameover) begin
          w_nextState = ST_OVER;
        end else if (i_fire) begin
          if (i_monsterSm[i_aim] && !w_killPending[i_aim]) w_fireHit = 1'b1;
          else w_fireMiss = 1'b1;
          w_nextState = ST_COOL;
        end
      end
      ST_COOL: begin
        if (|i_monsterGameover) w_nextState = ST_OVER;
        else if (r_coolCnt == COOLDOWN_CYCLES - COOL_W'(1)) w_nextState = ST_READY;
      end
      ST_OVER: if (!i_playFlag) w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    w_coolNext  = (r_state == ST_COOL && w_nextState == ST_COOL) ? r_coolCnt + COOL_W'(1) : '0;
    w_scoreNext = r_score;
    if (w_nextState == ST_IDLE) begin
      w_scoreNext = '0;
    end else if (w_fireHit) begin
      if (r_score != SCORE_MAX) w_scoreNext = r_score + SCORE_W'(1);
    end
`ifdef NEXYS_STARSHIP_MISS_PENALTY_EN
    else if (w_fireMiss) begin
      if (r_score != '0) w_scoreNext = r_score - SCORE_W'(1);
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= ST_IDLE;
      r_coolCnt      <= '0;
      r_score        <= '0;
      r_hitPulse     <= 1'b0;
      r_missPulse    <= 1'b0;
      r_gameoverCtrl <= 1'b0;
    end else begin
      r_state        <= w_nextState;
      r_coolCnt      <= w_coolNext;
      r_score        <= w_scoreNext;
      r_hitPulse     <= w_fireHit;
      r_missPulse    <= w_fireMiss;
      r_gameoverCtrl <= (w_nextState == ST_OVER);
    end
  end

  assign w_active = (w_nextState == ST_READY) || (w_nextState == ST_COOL);
  assign w_kill   = w_fireHit ? (NUM_LANES'(1) << i_aim) : '0;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    nexys_starship_lane_ctrl #(.KILL_HOLD(KILL_HOLD)) u_lane (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_active      (w_active),
      .i_kill        (w_kill[l]),
      .i_monsterSm   (i_monsterSm[l]),
      .o_killPending (w_killPending[l]),
      .o_monsterCtrl (o_monsterCtrl[l])
    );
  end

  assign o_gameoverCtrl = r_gameoverCtrl;
  assign o_score        = r_score;
  assign o_hitPulse     = r_hitPulse;
  assign o_missPulse    = r_missPulse;
  assign o_qIdle        = (r_state == ST_IDLE);
  assign o_qReady       = (r_state == ST_READY);
  assign o_qCool        = (r_state == ST_COOL);
  assign o_qOver        = (r_state == ST_OVER);

endmodule

// File: tb/tb_nexys_starship_shooter.sv
// Scoreboard bench for nexys_starship_shooter: a behavioural game model predicts every cycle's outputs.
`timescale 1ns/1ps
module tb_nexys_starship_shooter;
  import nexys_starship_pkg::*;

  logic       clk = 1'b0;
  logic       rstN;
  logic       playFlag, fire;
  logic [1:0] aim;
  logic [3:0] monsterSm, monsterGameover;
  logic [3:0] monsterCtrl;
  logic       gameoverCtrl;
  logic [7:0] score;
  logic       hitPulse, missPulse, qIdle, qReady, qCool, qOver;

  nexys_starship_shooter dut (
    .i_clk             (clk),
    .i_rst_n           (rstN),
    .i_playFlag        (playFlag),
    .i_fire            (fire),
    .i_aim             (aim),
    .i_monsterSm       (monsterSm),
    .i_monsterGameover (monsterGameover),
    .o_monsterCtrl     (monsterCtrl),
    .o_gameoverCtrl    (gameoverCtrl),
    .o_score           (score),
    .o_hitPulse        (hitPulse),
    .o_missPulse       (missPulse),
    .o_qIdle           (qIdle),
    .o_qReady          (qReady),
    .o_qCool           (qCool),
    .o_qOver           (qOver)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] ctrl;
    logic       go;
    logic [7:0] score;
    logic       hit;
    logic       miss;
  } expect_t;

  expect_t expQ[$];
  int testsRun = 0;
  int testsFailed = 0;

  // Model state: 0 idle, 1 ready, 2 cool, 3 over.
  int mState, mCnt, mScore;
  int mTimer[4];
  bit mPend[4];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, actual, expected);
    end
  endtask

  task automatic modelReset();
    mState = 0;
    mCnt   = 0;
    mScore = 0;
    for (int l = 0; l < 4; l++) begin
      mPend[l]  = 1'b0;
      mTimer[l] = 0;
    end
  endtask

  task automatic modelStep(input logic play, input logic fr, input logic [1:0] a,
                           input logic [3:0] sm, input logic [3:0] go, output expect_t e);
    int  nxt;
    bit  hit, miss, act;
    hit  = 0;
    miss = 0;
    nxt  = mState;
    if (mState == 0) begin
      if (play) nxt = 1;
    end else if (mState == 3) begin
      if (!play) nxt = 0;
    end else if (go != 4'b0000) begin
      nxt = 3;
    end else if (mState == 1) begin
      if (fr) begin
        if (sm[a] && !mPend[a]) hit = 1;
        else miss = 1;
        nxt = 2;
      end
    end else if (mCnt == 49) begin
      nxt = 1;
    end
    mCnt = (mState == 2 && nxt == 2) ? mCnt + 1 : 0;
    if (nxt == 0) mScore = 0;
    else if (hit && mScore < 255) mScore = mScore + 1;
`ifdef NEXYS_STARSHIP_MISS_PENALTY_EN
    else if (miss && mScore > 0) mScore = mScore - 1;
`endif
    act = (nxt == 1 || nxt == 2);
    e = '0;
    for (int l = 0; l < 4; l++) begin
      if (!act) begin
        mPend[l] = 0;
        mTimer[l] = 0;
      end else if (hit && int'(a) == l) begin
        mPend[l] = 1;
        mTimer[l] = 0;
      end else if (mPend[l]) begin
        if (!sm[l] || mTimer[l] == 7) mPend[l] = 0;
        else mTimer[l] = mTimer[l] + 1;
      end
      e.ctrl[l] = act && !mPend[l] && sm[l];
    end
    mState  = nxt;
    e.st    = 4'b0001 << nxt;
    e.go    = (nxt == 3);
    e.score = 8'(mScore);
    e.hit   = hit;
    e.miss  = miss;
  endtask

  task automatic applyStimulus(input logic play, input logic fr, input logic [1:0] a,
                               input logic [3:0] sm, input logic [3:0] go);
    expect_t e;
    playFlag        = play;
    fire            = fr;
    aim             = a;
    monsterSm       = sm;
    monsterGameover = go;
    modelStep(play, fr, a, sm, go, e);
    expQ.push_back(e);
    @(posedge clk);
    #1;
    e = expQ.pop_front();
    checkOutput("state", {28'd0, qOver, qCool, qReady, qIdle}, {28'd0, e.st});
    checkOutput("monsterCtrl", {28'd0, monsterCtrl}, {28'd0, e.ctrl});
    checkOutput("gameoverCtrl", {31'd0, gameoverCtrl}, {31'd0, e.go});
    checkOutput("score", {24'd0, score}, {24'd0, e.score});
    checkOutput("hitPulse", {31'd0, hitPulse}, {31'd0, e.hit});
    checkOutput("missPulse", {31'd0, missPulse}, {31'd0, e.miss});
    fire = 1'b0;
  endtask

  task automatic waitReady(input logic [3:0] sm);
    int n;
    n = 0;
    while (mState != 1 && n < 100) begin
      applyStimulus(1'b1, 1'b0, LANE_TOP, sm, 4'b0000);
      n++;
    end
    if (mState != 1) checkOutput("waitReady", 32'd0, 32'd1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "State"}, {28'd0, qOver, qCool, qReady, qIdle}, 32'h1);
    checkOutput({tag, "Score"}, {24'd0, score}, 32'd0);
    checkOutput({tag, "Ctrl"}, {28'd0, monsterCtrl}, 32'd0);
    checkOutput({tag, "Pulses"}, {29'd0, gameoverCtrl, hitPulse, missPulse}, 32'd0);
  endtask

  initial begin
    rstN = 1'b0;
    playFlag = 1'b0;
    fire = 1'b0;
    aim = 2'd0;
    monsterSm = 4'd0;
    monsterGameover = 4'd0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rstN = 1'b1;

    applyStimulus(1'b1, 1'b0, LANE_TOP, 4'b0000, 4'b0000);
    checkOutput("readyAfterPlay", {31'd0, qReady}, 32'd1);

    // Hit on the top lane; the lane SM drops its monster two cycles later.
    applyStimulus(1'b1, 1'b1, LANE_TOP, 4'b0001, 4'b0000);
    applyStimulus(1'b1, 1'b0, LANE_TOP, 4'b0001, 4'b0000);
    applyStimulus(1'b1, 1'b0, LANE_TOP, 4'b0001, 4'b0000);
    applyStimulus(1'b1, 1'b1, LANE_RIGHT, 4'b0000, 4'b0000);
    waitReady(4'b0000);

    // Misses at an empty bottom lane, the first on the very first READY cycle.
    applyStimulus(1'b1, 1'b1, LANE_BOTTOM, 4'b0000, 4'b0000);
    waitReady(4'b0000);
    applyStimulus(1'b1, 1'b1, LANE_BOTTOM, 4'b0000, 4'b0000);
    waitReady(4'b0000);

    // Right-lane monster spawns with the shot and is never dropped: hold times out.
    applyStimulus(1'b1, 1'b1, LANE_RIGHT, 4'b0010, 4'b0000);
    repeat (12) applyStimulus(1'b1, 1'b0, LANE_TOP, 4'b0010, 4'b0000);
    checkOutput("ctrlReleased", {31'd0, monsterCtrl[1]}, 32'd1);
    waitReady(4'b0010);

    // Game-over from the left lane beats a hitting fire.
    applyStimulus(1'b1, 1'b1, LANE_RIGHT, 4'b0010, 4'b1000);
    applyStimulus(1'b1, 1'b0, LANE_TOP, 4'b0010, 4'b1000);
    applyStimulus(1'b0, 1'b0, LANE_TOP, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 1'b0, LANE_TOP, 4'b0000, 4'b0000);

    // Score saturation with all lanes occupied.
    applyStimulus(1'b1, 1'b0, LANE_TOP, 4'b1111, 4'b0000);
    for (int i = 0; i < 300 && mScore < 255; i++) begin
      applyStimulus(1'b1, 1'b1, 2'(i), 4'b1111, 4'b0000);
      waitReady(4'b1111);
    end
    checkOutput("scoreSat", {24'd0, score}, 32'd255);
    applyStimulus(1'b1, 1'b1, LANE_LEFT, 4'b1111, 4'b0000);
    checkOutput("scoreHold", {24'd0, score}, 32'd255);
    repeat (3) applyStimulus(1'b1, 1'b0, LANE_TOP, 4'b1111, 4'b0000);

    // Asynchronous reset mid-game.
    #2;
    rstN = 1'b0;
    #1;
    checkResetOutputs("midReset");
    modelReset();
    @(posedge clk);
    #1;
    rstN = 1'b1;
    applyStimulus(1'b0, 1'b0, LANE_TOP, 4'b0000, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
